z2_cycle_ctrl: RTL and testbench
================================

// Module: z2_cycle_ctrl
// PURPOSE
//  Parametrised Zorro II slave-cycle controller for N bus targets (RAM, autoconfig, IDE regs, ...).
//  Synchronises the async 68k strobes, runs the shared IDLE/START/DATA/END cycle FSM and grants one target per cycle.
//  Drives DTACK from the granted target's ack, with an optional BERR watchdog.
//  Sits between the board top level and the per-target blocks, which consume z2_state and tgt_grant.
// PARAMETERS
//  NUM_TGT      4    number of target channels; index 0 = highest priority
//  SYNC_STAGES  2    flip-flop stages per strobe synchroniser; legal values 2..4
//  TIMEOUT_CYC  255  clk cycles allowed in DATA before BERR; legal values 2..2**TIMEOUT_W-1
//  TIMEOUT_W    8    width of the watchdog counter
// PORTS
//  clk        in   1        memory clock; all logic on the rising edge
//  reset      in   1        synchronous, active-high reset
//  as_n       in   1        raw asynchronous address strobe
//  uds_n      in   1        raw upper data strobe
//  lds_n      in   1        raw lower data strobe
//  rw         in   1        raw read/write; 1 = read
//  tgt_sel    in   NUM_TGT  per-target address decode hits; combinational, from the target blocks
//  tgt_ack    in   NUM_TGT  per-target data-ready; level, clk domain
//  as_n_s     out  1        synchronised as_n
//  uds_n_s    out  1        synchronised uds_n
//  lds_n_s    out  1        synchronised lds_n
//  rw_s       out  1        synchronised rw
//  z2_state   out  2        FSM state; encoding from the shared package
//  tgt_grant  out  NUM_TGT  one-hot grant; latched for the whole cycle
//  dtack_oe   out  1        1 = top level drives DTACK_n low
//  berr_oe    out  1        1 = top level drives BERR_n low; tied to 0 without Z2_TIMEOUT_BERR_EN
//  cycle_done out  1        one-clk pulse on every END->IDLE transition
// BEHAVIOUR
//  Reset: sync chains = 1; rw_s = 1; z2_state = IDLE; tgt_grant = 0; dtack_oe = berr_oe = cycle_done = 0; counter = 0.
//  Synchronisers: output latency is SYNC_STAGES clks. FSM and all outputs use only the synchronised strobes.
//  IDLE -> START
//   - Condition: as_n_s = 0 and |tgt_sel.
//   - tgt_grant latches the lowest set index of tgt_sel.
//   - tgt_sel changes later in the cycle are ignored.
//  START -> DATA
//   - Condition: uds_n_s = 0 or lds_n_s = 0.
//   - Watchdog counter cleared.
//  DATA -> END
//   - Condition: tgt_ack & tgt_grant is nonzero. Acks from non-granted targets are ignored.
//   - Effect: dtack_oe = 1 from the next clk.
//  END -> IDLE
//   - Condition: as_n_s = 1.
//   - Effect: clear tgt_grant, dtack_oe and berr_oe; pulse cycle_done.
//  Abort: as_n_s = 1 while in START or DATA -> IDLE. Grant clears, no dtack, no cycle_done pulse.
//  Simultaneous ack and abort in DATA: abort wins.
//  Back-to-back cycles: IDLE is re-entered for at least 1 clk between cycles.
//  Reset asserted mid-cycle: state, grant and oe outputs all return to reset values on the next edge.
// CONFIGURATION
//  Macro: Z2_TIMEOUT_BERR_EN
//  Defined:
//   - Counter increments every clk in DATA and saturates at TIMEOUT_CYC.
//   - If the counter equals TIMEOUT_CYC-1 and no ack arrives, next state = END with berr_oe = 1, dtack_oe = 0.
//   - If the ack arrives on that same clk, the ack wins (DTACK).
//  Undefined: no counter is built; berr_oe is constant 0; DATA waits indefinitely for an ack.
// STRUCTURE
//  Shared package z2_pkg:
//   - Z2_IDLE = 2'd0, Z2_START = 2'd1, Z2_DATA = 2'd2, Z2_END = 2'd3.
//   - This is the existing global state encoding; the target blocks use it unchanged.
//   - Function for the lowest-set-bit one-hot priority encode.
//  Sub-module z2_sync:
//   - Parameters: STAGES and RESET_VAL. One instance per strobe.
//  The top-level pad drivers (tristate DTACK_n/BERR_n/OVR_n) stay outside this block.
// TESTING
//  1. Read, NUM_TGT=4, tgt_sel=4'b0110, ack[1] 3 clks after DATA
//     -> grant=4'b0010; dtack_oe rises 1 clk after ack; cycle_done pulses once after as_n rises.
//  2. Write with uds_n=1, lds_n=0
//     -> START->DATA on synchronised lds; ack[2] while grant=bit1 is ignored and the FSM stays in DATA.
//  3. as_n deasserted in DATA before any ack
//     -> IDLE within SYNC_STAGES+1 clks; dtack_oe and cycle_done never assert.
//  4. Z2_TIMEOUT_BERR_EN, TIMEOUT_CYC=16, no ack
//     -> berr_oe = 1 exactly 16 clks after DATA entry; held until as_n_s = 1.
//  5. Watchdog race: ack and timeout on the same clk -> dtack_oe = 1, berr_oe = 0.
//  6. reset pulsed for 1 clk while in END -> next clk: z2_state = IDLE, grant = 0, dtack_oe = 0.

Source files
------------

// File: rtl/z2_pkg.sv
// Shared Zorro II cycle definitions: global FSM state encoding and the
// lowest-set-bit priority encoder used for target grants.
package z2_pkg;

  typedef enum logic [1:0] {
    Z2_IDLE  = 2'd0,
    Z2_START = 2'd1,
    Z2_DATA  = 2'd2,
    Z2_END   = 2'd3
  } z2_state_t;

  // Isolates the lowest set bit; supports up to 32 target channels.
  function automatic logic [31:0] z2_lsb_onehot(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/z2_sync.sv
// Multi-stage flip-flop synchroniser for one asynchronous 68k bus signal.
module z2_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= {STAGES{RESET_VAL}};
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/z2_cycle_ctrl.sv
// Zorro II slave-cycle controller: strobe sync, cycle FSM, target grant, DTACK/BERR.
// Optional BERR watchdog enabled by defining Z2_TIMEOUT_BERR_EN.
module z2_cycle_ctrl
  import z2_pkg::*;
#(
  parameter int unsigned NUM_TGT     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               as_n,
  input  logic               uds_n,
  input  logic               lds_n,
  input  logic               rw,
  input  logic [NUM_TGT-1:0] tgt_sel,
  input  logic [NUM_TGT-1:0] tgt_ack,
  output logic               as_n_s,
  output logic               uds_n_s,
  output logic               lds_n_s,
  output logic               rw_s,
  output logic [1:0]         z2_state,
  output logic [NUM_TGT-1:0] tgt_grant,
  output logic               dtack_oe,
  output logic               berr_oe,
  output logic               cycle_done
);

  z2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_as  (.clk(clk), .reset(reset), .d(as_n),  .q(as_n_s));
  z2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_uds (.clk(clk), .reset(reset), .d(uds_n), .q(uds_n_s));
  z2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_lds (.clk(clk), .reset(reset), .d(lds_n), .q(lds_n_s));
  z2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rw  (.clk(clk), .reset(reset), .d(rw),    .q(rw_s));

  z2_state_t          st;
  logic [NUM_TGT-1:0] sel_oh;

  assign sel_oh   = NUM_TGT'(z2_lsb_onehot(32'(tgt_sel)));
  assign z2_state = st;

`ifdef Z2_TIMEOUT_BERR_EN
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = TIMEOUT_W'(TIMEOUT_CYC);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 berr_q;
  assign berr_oe = berr_q;
`else
  logic [TIMEOUT_W-1:0] unused_wd_last;
  assign unused_wd_last = TIMEOUT_W'(TIMEOUT_CYC - 1);
  assign berr_oe = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= Z2_IDLE;
      tgt_grant  <= '0;
      dtack_oe   <= 1'b0;
      cycle_done <= 1'b0;
`ifdef Z2_TIMEOUT_BERR_EN
      wd_cnt     <= '0;
      berr_q     <= 1'b0;
`endif
    end else begin
      cycle_done <= 1'b0;
      case (st)
        Z2_IDLE: begin
          if (!as_n_s && (|tgt_sel)) begin
            st        <= Z2_START;
            tgt_grant <= sel_oh;
          end
        end
        Z2_START: begin
          if (as_n_s) begin
            st        <= Z2_IDLE;
            tgt_grant <= '0;
          end else if (!uds_n_s || !lds_n_s) begin
            st <= Z2_DATA;
`ifdef Z2_TIMEOUT_BERR_EN
            wd_cnt <= '0;
`endif
          end
        end
        Z2_DATA: begin
`ifdef Z2_TIMEOUT_BERR_EN
          if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + TIMEOUT_W'(1);
`endif
          // Priority: abort, then ack, then watchdog expiry.
          if (as_n_s) begin
            st        <= Z2_IDLE;
            tgt_grant <= '0;
          end else if (|(tgt_ack & tgt_grant)) begin
            st       <= Z2_END;
            dtack_oe <= 1'b1;
          end
`ifdef Z2_TIMEOUT_BERR_EN
          else if (wd_cnt == WD_LAST) begin
            st     <= Z2_END;
            berr_q <= 1'b1;
          end
`endif
        end
        Z2_END: begin
          if (as_n_s) begin
            st         <= Z2_IDLE;
            tgt_grant  <= '0;
            dtack_oe   <= 1'b0;
            cycle_done <= 1'b1;
`ifdef Z2_TIMEOUT_BERR_EN
            berr_q     <= 1'b0;
`endif
          end
        end
        default: st <= Z2_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// Directed bench for z2_cycle_ctrl: grant/ack table plus multi-cycle corner sequences.
// Watchdog sequences depend on Z2_TIMEOUT_BERR_EN matching the RTL build.
module tb_z2_cycle_ctrl;
  import z2_pkg::*;

  logic       clk = 1'b0;
  logic       reset, as_n, uds_n, lds_n, rw;
  logic [3:0] tgt_sel, tgt_ack;
  logic       as_n_s, uds_n_s, lds_n_s, rw_s;
  logic [1:0] z2_state;
  logic [3:0] tgt_grant;
  logic       dtack_oe, berr_oe, cycle_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  z2_cycle_ctrl #(
    .NUM_TGT(4), .SYNC_STAGES(2), .TIMEOUT_CYC(16), .TIMEOUT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
    .tgt_sel(tgt_sel), .tgt_ack(tgt_ack),
    .as_n_s(as_n_s), .uds_n_s(uds_n_s), .lds_n_s(lds_n_s), .rw_s(rw_s),
    .z2_state(z2_state), .tgt_grant(tgt_grant), .dtack_oe(dtack_oe),
    .berr_oe(berr_oe), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] ack;
    logic [3:0] grant;
    logic       dtack;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int unsigned max, input string nm);
    int unsigned n = 0;
    while (z2_state !== s && n < max) begin
      tick();
      n++;
    end
    check(nm, 32'(z2_state), 32'(s));
  endtask

  task automatic begin_cycle(input logic [3:0] sel, input logic r, input logic u, input logic l);
    tgt_sel = sel;
    rw      = r;
    uds_n   = u;
    lds_n   = l;
    as_n    = 1'b0;
  endtask

  // Releases the bus and counts cycle_done pulses while the FSM returns to IDLE.
  task automatic release_bus(output int unsigned pulses);
    pulses  = 0;
    as_n    = 1'b1;
    uds_n   = 1'b1;
    lds_n   = 1'b1;
    tgt_ack = '0;
    tgt_sel = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cycle_done) pulses++;
    end
  endtask

  initial begin
    int unsigned pulses, n;
    logic saw_dtack, saw_done;

    tbl[0] = '{sel: 4'b0001, ack: 4'b0001, grant: 4'b0001, dtack: 1'b1};
    tbl[1] = '{sel: 4'b1000, ack: 4'b1000, grant: 4'b1000, dtack: 1'b1};
    tbl[2] = '{sel: 4'b1111, ack: 4'b0001, grant: 4'b0001, dtack: 1'b1};
    tbl[3] = '{sel: 4'b1100, ack: 4'b0100, grant: 4'b0100, dtack: 1'b1};
    tbl[4] = '{sel: 4'b0110, ack: 4'b0100, grant: 4'b0010, dtack: 1'b0};
    tbl[5] = '{sel: 4'b1010, ack: 4'b1000, grant: 4'b0010, dtack: 1'b0};
    tbl[6] = '{sel: 4'b0000, ack: 4'b0001, grant: 4'b0000, dtack: 1'b0};

    reset = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
    tgt_sel = 4'b0001; tgt_ack = 4'b0001;
    repeat (4) tick();
    check("rst_as_s", 32'(as_n_s), 32'd1);
    check("rst_rw_s", 32'(rw_s), 32'd1);
    check("rst_state", 32'(z2_state), 32'(Z2_IDLE));
    check("rst_grant", 32'(tgt_grant), 32'd0);
    check("rst_oe", 32'({dtack_oe, berr_oe, cycle_done}), 32'd0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; tgt_sel = '0; tgt_ack = '0;
    reset = 1'b0;
    repeat (3) tick();

    // Grant priority and ack filtering table
    foreach (tbl[i]) begin
      begin_cycle(tbl[i].sel, 1'b1, 1'b0, 1'b0);
      if (tbl[i].grant == 4'b0000) begin
        repeat (6) tick();
        check($sformatf("tbl%0d_nosel_state", i), 32'(z2_state), 32'(Z2_IDLE));
        check($sformatf("tbl%0d_nosel_grant", i), 32'(tgt_grant), 32'd0);
        release_bus(pulses);
        continue;
      end
      wait_state(Z2_START, 8, $sformatf("tbl%0d_start", i));
      check($sformatf("tbl%0d_grant", i), 32'(tgt_grant), 32'(tbl[i].grant));
      tgt_sel = ~tbl[i].sel;
      wait_state(Z2_DATA, 4, $sformatf("tbl%0d_data", i));
      tgt_ack = tbl[i].ack;
      if (tbl[i].dtack) begin
        wait_state(Z2_END, 4, $sformatf("tbl%0d_end", i));
      end else begin
        repeat (4) tick();
        check($sformatf("tbl%0d_hold", i), 32'(z2_state), 32'(Z2_DATA));
      end
      check($sformatf("tbl%0d_dtack", i), 32'(dtack_oe), 32'(tbl[i].dtack));
      check($sformatf("tbl%0d_grant_held", i), 32'(tgt_grant), 32'(tbl[i].grant));
      release_bus(pulses);
      check($sformatf("tbl%0d_done", i), pulses, 32'(tbl[i].dtack));
      check($sformatf("tbl%0d_idle_grant", i), 32'(tgt_grant), 32'd0);
    end

    // Read, ack[1] three clocks after DATA entry
    begin_cycle(4'b0110, 1'b1, 1'b0, 1'b0);
    wait_state(Z2_START, 8, "rd_start");
    check("rd_grant", 32'(tgt_grant), 32'b0010);
    wait_state(Z2_DATA, 4, "rd_data");
    repeat (3) tick();
    tgt_ack = 4'b0010;
    check("rd_dtack_before", 32'(dtack_oe), 32'd0);
    tick();
    check("rd_dtack_after", 32'(dtack_oe), 32'd1);
    check("rd_state_end", 32'(z2_state), 32'(Z2_END));
    release_bus(pulses);
    check("rd_done_once", pulses, 32'd1);
    check("rd_dtack_clr", 32'(dtack_oe), 32'd0);

    // Write on lower strobe only; foreign ack ignored
    begin_cycle(4'b0010, 1'b0, 1'b1, 1'b0);
    wait_state(Z2_DATA, 10, "wr_data");
    check("wr_rw_s", 32'(rw_s), 32'd0);
    tgt_ack = 4'b0100;
    repeat (5) tick();
    check("wr_foreign_ack", 32'(z2_state), 32'(Z2_DATA));
    check("wr_no_dtack", 32'(dtack_oe), 32'd0);
    tgt_ack = 4'b0010;
    tick();
    check("wr_end", 32'(z2_state), 32'(Z2_END));
    release_bus(pulses);
    check("wr_done_once", pulses, 32'd1);

    // Abort in DATA before any ack
    begin_cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    wait_state(Z2_DATA, 10, "ab_data");
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tgt_sel = '0;
    n = 0; saw_dtack = 1'b0; saw_done = 1'b0;
    while (z2_state !== Z2_IDLE && n < 10) begin
      tick();
      n++;
      saw_dtack |= dtack_oe;
      saw_done  |= cycle_done;
    end
    check("ab_latency_ok", 32'(n <= 3), 32'd1);
    repeat (3) begin
      tick();
      saw_dtack |= dtack_oe;
      saw_done  |= cycle_done;
    end
    check("ab_no_dtack", 32'(saw_dtack), 32'd0);
    check("ab_no_done", 32'(saw_done), 32'd0);
    check("ab_grant_clr", 32'(tgt_grant), 32'd0);

    // No ack: watchdog expiry after 16 clocks in DATA
    begin_cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    wait_state(Z2_DATA, 10, "wd_data");
    repeat (15) tick();
    check("wd_pre_berr", 32'(berr_oe), 32'd0);
    check("wd_pre_state", 32'(z2_state), 32'(Z2_DATA));
    tick();
`ifdef Z2_TIMEOUT_BERR_EN
    check("wd_berr", 32'(berr_oe), 32'd1);
    check("wd_state_end", 32'(z2_state), 32'(Z2_END));
    check("wd_no_dtack", 32'(dtack_oe), 32'd0);
    repeat (5) tick();
    check("wd_berr_held", 32'(berr_oe), 32'd1);
`else
    check("wd_no_berr", 32'(berr_oe), 32'd0);
    check("wd_still_data", 32'(z2_state), 32'(Z2_DATA));
    tgt_ack = 4'b0100;
    tick();
    check("wd_late_ack", 32'(dtack_oe), 32'd1);
`endif
    release_bus(pulses);
    check("wd_berr_clr", 32'(berr_oe), 32'd0);
    check("wd_idle", 32'(z2_state), 32'(Z2_IDLE));

    // Ack lands on the watchdog's final clock
    begin_cycle(4'b1000, 1'b1, 1'b0, 1'b0);
    wait_state(Z2_DATA, 10, "race_data");
    repeat (15) tick();
    tgt_ack = 4'b1000;
    tick();
    check("race_dtack", 32'(dtack_oe), 32'd1);
    check("race_berr", 32'(berr_oe), 32'd0);

    // One-clock reset while in END
    tgt_sel = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_end_state", 32'(z2_state), 32'(Z2_IDLE));
    check("rst_end_grant", 32'(tgt_grant), 32'd0);
    check("rst_end_dtack", 32'(dtack_oe), 32'd0);
    release_bus(pulses);
    check("rst_end_no_done", pulses, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
